ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage (ALU output) and the memory stage of the RISC-V core.
- Captures the ALU result, store data, destination register and memory/writeback control bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a memory-stage stall never creates a combinational ready path back into execute.
- Exports a forwarding tap from the head entry for the operand-select logic in front of the ALU.

---
 rtl/core_pkg.sv | 34 +++
 rtl/pipe_skid_buf.sv | 99 +++++++++
 rtl/ex_mem_reg.sv | 71 +++++++
 tb/tb_ex_mem_reg.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: datapath widths, EX/MEM payload layout, skid buffer
// state encoding and the capture-sanitising rule applied at the EX/MEM boundary.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_payload_t;

  localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  // x0 is never written, and a store takes precedence over a conflicting load.
  function automatic ex_mem_payload_t sanitize_payload(input ex_mem_payload_t p);
    ex_mem_payload_t s;
    s           = p;
    s.reg_write = p.reg_write && (p.rd != '0);
    s.mem_read  = p.mem_read && !p.mem_write;
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is registered so a
// downstream stall never reaches the upstream stage combinationally.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import core_pkg::*;

  skid_state_t  r_state;
  skid_state_t  w_state_next;
  logic         r_in_ready;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;

  logic w_accept;
  logic w_consume;
  logic w_load_head_in;
  logic w_load_head_skid;
  logic w_load_skid;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_in_ready;
  assign out_data  = r_head;
  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    // Flush only clears validity; payload registers keep their contents.
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_next   = FULL;
            w_load_head_in = 1'b1;
          end
        end
        FULL: begin
          if (w_accept && w_consume) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = SKID;
            w_load_skid  = 1'b1;
          end else if (w_consume) begin
            w_state_next = EMPTY;
          end
        end
        SKID: begin
          if (w_consume) begin
            w_state_next     = FULL;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != SKID);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= in_data;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: sanitises the execute-stage payload, buffers it in
// a 2-entry skid buffer and exposes a forwarding tap from the head entry.
module ex_mem_reg
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_alu_result,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
);

  ex_mem_payload_t w_in_raw;
  ex_mem_payload_t w_in_clean;
  ex_mem_payload_t w_head;

  always_comb begin
    w_in_raw.alu_result = in_alu_result;
    w_in_raw.store_data = in_store_data;
    w_in_raw.rd         = in_rd;
    w_in_raw.reg_write  = in_reg_write;
    w_in_raw.mem_read   = in_mem_read;
    w_in_raw.mem_write  = in_mem_write;
  end

  assign w_in_clean = sanitize_payload(w_in_raw);

  pipe_skid_buf #(
    .W(EX_MEM_PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_clean),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign out_alu_result = w_head.alu_result;
  assign out_store_data = w_head.store_data;
  assign out_rd         = w_head.rd;
  assign out_reg_write  = w_head.reg_write;
  assign out_mem_read   = w_head.mem_read;
  assign out_mem_write  = w_head.mem_write;

  // Loads are excluded: their data only exists after the memory access.
  assign fwd_valid = out_valid && w_head.reg_write && !w_head.mem_read;
  assign fwd_rd    = w_head.rd;
  assign fwd_data  = w_head.alu_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus a randomized run
// against a queue-based FIFO reference model.
module tb_ex_mem_reg;
  import core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [XLEN-1:0]       in_alu_result = '0;
  logic [XLEN-1:0]       in_store_data = '0;
  logic [REG_ADDR_W-1:0] in_rd = '0;
  logic                  in_reg_write = 1'b0;
  logic                  in_mem_read = 1'b0;
  logic                  in_mem_write = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [XLEN-1:0]       out_alu_result;
  logic [XLEN-1:0]       out_store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [XLEN-1:0]       fwd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of held instructions, at most two.
  ex_mem_payload_t model_q[$];

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
  );

  task automatic drive(input logic v, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] sd,
                       input logic [REG_ADDR_W-1:0] rd, input logic rw, input logic mr,
                       input logic mw);
    in_valid      = v;
    in_alu_result = alu;
    in_store_data = sd;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_read   = mr;
    in_mem_write  = mw;
  endtask

  // One clock: update the model from the inputs presented at the edge, then
  // leave 1 time unit so outputs are sampled clear of the edge.
  task automatic tick();
    bit              acc;
    bit              cons;
    ex_mem_payload_t p;
    @(posedge clk);
    acc  = in_valid && (model_q.size() < 2);
    cons = (model_q.size() > 0) && out_ready;
    if (cons)
      $display("xfer alu=%08h sd=%08h rd=%0d rw=%0b mr=%0b mw=%0b", model_q[0].alu_result,
               model_q[0].store_data, model_q[0].rd, model_q[0].reg_write,
               model_q[0].mem_read, model_q[0].mem_write);
    if (flush) begin
      model_q.delete();
    end else begin
      if (cons) void'(model_q.pop_front());
      if (acc) begin
        p.alu_result = in_alu_result;
        p.store_data = in_store_data;
        p.rd         = in_rd;
        p.reg_write  = (in_rd == 0) ? 1'b0 : in_reg_write;
        p.mem_write  = in_mem_write;
        p.mem_read   = in_mem_write ? 1'b0 : in_mem_read;
        model_q.push_back(p);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++;
    if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %0b want 0", fwd_valid); end
    checks++;
    if ({out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write} !== '0) begin
      errors++;
      $display("FAIL reset_payload got alu=%08h sd=%08h rd=%0d want zero", out_alu_result, out_store_data, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++;
    if (out_alu_result !== 32'h10) begin errors++; $display("FAIL single_alu got %08h want 00000010", out_alu_result); end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h10) begin
      errors++;
      $display("FAIL single_fwd got v=%0b rd=%0d d=%08h want v=1 rd=5 d=00000010", fwd_valid, fwd_rd, fwd_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, XLEN'(i), XLEN'(i * 16), 5'(i + 8), 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_alu_result !== XLEN'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%0b alu=%08h rdy=%0b want v=1 alu=%08h rdy=1", i, out_valid,
                 out_alu_result, in_ready, i);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'hA || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_first got v=%0b alu=%08h rdy=%0b want v=1 alu=0000000a rdy=1", out_valid, out_alu_result, in_ready);
    end
    drive(1'b1, 32'hB, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      errors++;
      $display("FAIL skid_full got rdy=%0b alu=%08h want rdy=0 alu=0000000a", in_ready, out_alu_result);
    end
    drive(1'b1, 32'hC, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_alu_result !== 32'hA || out_rd !== 5'd1) begin
      errors++;
      $display("FAIL skid_stall got rdy=%0b alu=%08h rd=%0d want rdy=0 alu=0000000a rd=1", in_ready, out_alu_result, out_rd);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'hB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_second got v=%0b alu=%08h rdy=%0b want v=1 alu=0000000b rdy=1", out_valid, out_alu_result, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain got %0b want 0 (0xC must not appear)", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hC, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_skid got v=%0b rdy=%0b fwd=%0b want v=0 rdy=1 fwd=0", out_valid, in_ready, fwd_valid);
    end
    checks++;
    if (out_alu_result !== 32'hA) begin errors++; $display("FAIL flush_hold got %08h want 0000000a", out_alu_result); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got %0b want 0", i, out_valid); end
    end
    // Flush from FULL while an input is offered and the head is being consumed.
    drive(1'b1, 32'hD, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hE, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_result !== 32'hD) begin
      errors++;
      $display("FAIL flush_full got v=%0b rdy=%0b alu=%08h want v=0 rdy=1 alu=0000000d", out_valid, in_ready, out_alu_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_quiet got %0b want 0", out_valid); end
  endtask

  task automatic test_sanitise();
    out_ready = 1'b1;
    drive(1'b1, 32'h55, 32'h66, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL sanit_x0 got v=%0b rw=%0b fwd=%0b want v=1 rw=0 fwd=0", out_valid, out_reg_write, fwd_valid);
    end
    drive(1'b1, 32'h77, 32'h88, 5'd3, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_mem_write !== 1'b1 || out_mem_read !== 1'b0 || out_store_data !== 32'h88) begin
      errors++;
      $display("FAIL sanit_rw got mw=%0b mr=%0b sd=%08h want mw=1 mr=0 sd=00000088", out_mem_write, out_mem_read, out_store_data);
    end
    checks++;
    if (out_reg_write !== 1'b1 || fwd_valid !== 1'b1) begin
      errors++;
      $display("FAIL sanit_rw_fwd got rw=%0b fwd=%0b want rw=1 fwd=1", out_reg_write, fwd_valid);
    end
    tick();
  endtask

  task automatic test_load_fwd();
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_mem_read !== 1'b1 || fwd_valid !== 1'b0 || fwd_rd !== 5'd7) begin
        errors++;
        $display("FAIL load_fwd_%0d got v=%0b mr=%0b fwd=%0b rd=%0d want v=1 mr=1 fwd=0 rd=7", i, out_valid,
                 out_mem_read, fwd_valid, fwd_rd);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    ex_mem_payload_t exp_head;
    logic            exp_fwd;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 9) < 7), $urandom(), $urandom(),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom()),
            1'($urandom()), 1'($urandom()), 1'($urandom()));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
        errors++;
        $display("FAIL rand_hs_%0d got v=%0b rdy=%0b want v=%0b rdy=%0b", n, out_valid, in_ready,
                 model_q.size() > 0, model_q.size() < 2);
      end
      if (model_q.size() > 0) begin
        exp_head = model_q[0];
        exp_fwd  = exp_head.reg_write && !exp_head.mem_read;
        checks++;
        if ({out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write} !== exp_head) begin
          errors++;
          $display("FAIL rand_payload_%0d got alu=%08h sd=%08h rd=%0d f=%0b%0b%0b want alu=%08h sd=%08h rd=%0d f=%0b%0b%0b",
                   n, out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write,
                   exp_head.alu_result, exp_head.store_data, exp_head.rd, exp_head.reg_write,
                   exp_head.mem_read, exp_head.mem_write);
        end
        checks++;
        if (fwd_valid !== exp_fwd || fwd_rd !== exp_head.rd || fwd_data !== exp_head.alu_result) begin
          errors++;
          $display("FAIL rand_fwd_%0d got v=%0b rd=%0d d=%08h want v=%0b rd=%0d d=%08h", n, fwd_valid, fwd_rd,
                   fwd_data, exp_fwd, exp_head.rd, exp_head.alu_result);
        end
      end else begin
        checks++;
        if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rand_fwd_idle_%0d got %0b want 0", n, fwd_valid); end
      end
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h5678, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_q.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got v=%0b rdy=%0b fwd=%0b want v=0 rdy=1 fwd=0", out_valid, in_ready, fwd_valid);
    end
    checks++;
    if (out_alu_result !== '0 || out_rd !== '0) begin
      errors++;
      $display("FAIL async_rst_payload got alu=%08h rd=%0d want 0", out_alu_result, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_after got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_sanitise();
    test_load_fwd();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
